// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: synchronises encoder keypresses, steers each digit into the
// user-input or setpoint store, compares the two on enter and enforces a timed lockout
// after repeated mismatches.
module keypad_entry_ctrl #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned DW          = 4,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [DW-1:0]        key_code,
  input  logic                 mode_sel,
  input  logic                 enter,
  input  logic                 clear,
  output logic [DIGITS*DW-1:0] ui_buf,
  output logic [DIGITS*DW-1:0] sp_buf,
  output logic [3:0]           ui_cnt,
  output logic [3:0]           sp_cnt,
  output logic                 match,
  output logic                 fail,
  output logic                 locked
);

  localparam int unsigned BW = DIGITS * DW;
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

  localparam logic [3:0]    CntFull  = 4'(DIGITS);
  localparam logic [FW-1:0] FailMax  = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LockLast = LW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StEntry, StCheck, StLockout} state_e;

  state_e          state_q, state_d;
  logic            kv_s1_q, kv_s2_q, kv_s3_q;
  logic [DW-1:0]   code_s1_q, code_s2_q;
  logic [BW-1:0]   ui_buf_q, ui_buf_d, sp_buf_q, sp_buf_d;
  logic [3:0]      ui_cnt_q, ui_cnt_d, sp_cnt_q, sp_cnt_d;
  logic [FW-1:0]   fail_cnt_q, fail_cnt_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            match_q, match_d, fail_q, fail_d, locked_q, locked_d;

  logic key_ev, allow_in, go_check, key_ui, key_sp, clr_ui, clr_sp;

  // Two-flop synchroniser on the async encoder outputs, plus a delay stage for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kv_s1_q   <= 1'b0;
      kv_s2_q   <= 1'b0;
      kv_s3_q   <= 1'b0;
      code_s1_q <= '0;
      code_s2_q <= '0;
    end else begin
      kv_s1_q   <= key_valid;
      kv_s2_q   <= kv_s1_q;
      kv_s3_q   <= kv_s2_q;
      code_s1_q <= key_code;
      code_s2_q <= code_s1_q;
    end
  end

  assign key_ev = kv_s2_q & ~kv_s3_q;

  // Next-state logic for the sequencer and both digit stores.
  always_comb begin
    state_d    = state_q;
    ui_buf_d   = ui_buf_q;
    sp_buf_d   = sp_buf_q;
    ui_cnt_d   = ui_cnt_q;
    sp_cnt_d   = sp_cnt_q;
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = lock_cnt_q;
    match_d    = 1'b0;
    fail_d     = 1'b0;

    allow_in = (state_q == StIdle) || (state_q == StEntry);
    // An accepted enter freezes the stores for that cycle so the compare sees what was checked.
    go_check = (state_q == StEntry) && enter && (ui_cnt_q == CntFull) && (sp_cnt_q == CntFull);
    clr_ui   = allow_in && !go_check && clear && !mode_sel;
    clr_sp   = allow_in && !go_check && clear && mode_sel;
    // Clear beats a simultaneous keypress to the same store; a full store drops the digit.
    key_ui   = allow_in && !go_check && key_ev && !mode_sel && !clear && (ui_cnt_q != CntFull);
    key_sp   = allow_in && !go_check && key_ev && mode_sel && !clear && (sp_cnt_q != CntFull);

    if (clr_ui) begin
      ui_buf_d = '0;
      ui_cnt_d = '0;
    end else if (key_ui) begin
      ui_buf_d = {ui_buf_q[BW-DW-1:0], code_s2_q};
      ui_cnt_d = ui_cnt_q + 4'd1;
    end

    if (clr_sp) begin
      sp_buf_d = '0;
      sp_cnt_d = '0;
    end else if (key_sp) begin
      sp_buf_d = {sp_buf_q[BW-DW-1:0], code_s2_q};
      sp_cnt_d = sp_cnt_q + 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (key_ui || key_sp) state_d = StEntry;
      end
      StEntry: begin
        if (go_check) begin
          state_d = StCheck;
        end else if (clear && (ui_cnt_d == 4'd0) && (sp_cnt_d == 4'd0)) begin
          state_d = StIdle;
        end
      end
      StCheck: begin
        ui_buf_d   = '0;
        ui_cnt_d   = '0;
        lock_cnt_d = '0;
        if (ui_buf_q == sp_buf_q) begin
          match_d    = 1'b1;
          fail_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          fail_d     = 1'b1;
          fail_cnt_d = fail_cnt_q + FW'(1);
          state_d    = (fail_cnt_d == FailMax) ? StLockout : StIdle;
        end
      end
      StLockout: begin
        if (lock_cnt_q == LockLast) begin
          fail_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    locked_d = (state_d == StLockout);
  end

  // State, stores and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ui_buf_q   <= '0;
      sp_buf_q   <= '0;
      ui_cnt_q   <= '0;
      sp_cnt_q   <= '0;
      fail_cnt_q <= '0;
      lock_cnt_q <= '0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ui_buf_q   <= ui_buf_d;
      sp_buf_q   <= sp_buf_d;
      ui_cnt_q   <= ui_cnt_d;
      sp_cnt_q   <= sp_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
    end
  end

  assign ui_buf = ui_buf_q;
  assign sp_buf = sp_buf_q;
  assign ui_cnt = ui_cnt_q;
  assign sp_cnt = sp_cnt_q;
  assign match  = match_q;
  assign fail   = fail_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed self-checking bench for keypad_entry_ctrl.
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        mode_sel;
  logic        enter;
  logic        clear;
  logic [31:0] ui_buf, sp_buf;
  logic [3:0]  ui_cnt, sp_cnt;
  logic        match, fail, locked;

  int checks   = 0;
  int failures = 0;

  keypad_entry_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .mode_sel  (mode_sel),
    .enter     (enter),
    .clear     (clear),
    .ui_buf    (ui_buf),
    .sp_buf    (sp_buf),
    .ui_cnt    (ui_cnt),
    .sp_cnt    (sp_cnt),
    .match     (match),
    .fail      (fail),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic press(input logic m, input logic [3:0] c, input int hold);
    mode_sel  = m;
    key_code  = c;
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_buf(input logic m);
    mode_sel = m;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
  endtask

  // Pulse enter before edge N, return at the falling edge after N+1 having checked the pulses.
  task automatic do_enter(input string tag, input logic exp_match, input logic exp_fail);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    check_eq({tag, "_match"}, {31'd0, match}, {31'd0, exp_match});
    check_eq({tag, "_fail"}, {31'd0, fail}, {31'd0, exp_fail});
  endtask

  task automatic load_ui_nines();
    for (int i = 0; i < 8; i++) press(1'b0, 4'd9, 2);
  endtask

  int lock_len;

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_code = '0; mode_sel = 1'b0; enter = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ui_buf", ui_buf, 32'h0);
    check_eq("rst_sp_buf", sp_buf, 32'h0);
    check_eq("rst_cnts", {24'd0, ui_cnt, sp_cnt}, 32'h0);
    check_eq("rst_flags", {29'd0, match, fail, locked}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: matching entry
    for (int i = 1; i <= 8; i++) press(1'b1, 4'(i), 2);
    for (int i = 1; i <= 8; i++) press(1'b0, 4'(i), 2);
    check_eq("t1_sp_buf", sp_buf, 32'h12345678);
    check_eq("t1_sp_cnt", {28'd0, sp_cnt}, 32'd8);
    check_eq("t1_ui_buf", ui_buf, 32'h12345678);
    do_enter("t1", 1'b1, 1'b0);
    check_eq("t1_ui_cnt_cleared", {28'd0, ui_cnt}, 32'd0);
    @(negedge clk);
    check_eq("t1_match_one_cycle", {31'd0, match}, 32'd0);
    check_eq("t1_sp_kept", sp_buf, 32'h12345678);

    // T2: long hold gives one digit; update lands two edges after first sample
    mode_sel = 1'b0; key_code = 4'd9; key_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("t2_latency_n1", {28'd0, ui_cnt}, 32'd0);
    @(negedge clk);
    check_eq("t2_latency_n2", {28'd0, ui_cnt}, 32'd1);
    repeat (8) @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t2_ui_buf", ui_buf, 32'h00000009);
    check_eq("t2_ui_cnt", {28'd0, ui_cnt}, 32'd1);

    // T3: overflow dropped; enter with short SP ignored
    clear_buf(1'b0);
    check_eq("t3_ui_clr", {28'd0, ui_cnt}, 32'd0);
    clear_buf(1'b1);
    check_eq("t3_sp_clr", sp_buf, 32'h0);
    for (int i = 1; i <= 5; i++) press(1'b1, 4'(i), 2);
    for (int i = 1; i <= 9; i++) press(1'b0, 4'(i), 2);
    check_eq("t3_ui_buf", ui_buf, 32'h12345678);
    check_eq("t3_ui_cnt", {28'd0, ui_cnt}, 32'd8);
    check_eq("t3_sp_cnt", {28'd0, sp_cnt}, 32'd5);
    do_enter("t3", 1'b0, 1'b0);
    @(negedge clk);
    check_eq("t3_no_pulse_late", {30'd0, match, fail}, 32'd0);
    check_eq("t3_ui_kept", {28'd0, ui_cnt}, 32'd8);

    // T4: three mismatches lock out for 16 cycles
    for (int i = 6; i <= 8; i++) press(1'b1, 4'(i), 2);
    check_eq("t4_sp_buf", sp_buf, 32'h12345678);
    clear_buf(1'b0);
    load_ui_nines();
    do_enter("t4_f1", 1'b0, 1'b1);
    check_eq("t4_f1_unlocked", {31'd0, locked}, 32'd0);
    load_ui_nines();
    do_enter("t4_f2", 1'b0, 1'b1);
    load_ui_nines();
    do_enter("t4_f3", 1'b0, 1'b1);
    lock_len = (locked === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40 && locked === 1'b1; i++) begin
      if (i == 2) begin mode_sel = 1'b0; key_code = 4'd5; key_valid = 1'b1; end
      if (i == 5) key_valid = 1'b0;
      if (i == 6) enter = 1'b1;
      if (i == 7) enter = 1'b0;
      @(negedge clk);
      if (locked === 1'b1) lock_len++;
    end
    key_valid = 1'b0; enter = 1'b0;
    check_eq("t4_lock_len", lock_len, 32'd16);
    check_eq("t4_keys_ignored", {28'd0, ui_cnt}, 32'd0);
    press(1'b0, 4'd3, 2);
    check_eq("t4_idle_accepts", ui_buf, 32'h00000003);

    // T5: clear and key event on UI in the same cycle
    mode_sel = 1'b0; key_code = 4'd7; key_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    key_valid = 1'b0;
    check_eq("t5_ui_cnt", {28'd0, ui_cnt}, 32'd0);
    check_eq("t5_ui_buf", ui_buf, 32'h0);
    check_eq("t5_sp_buf", sp_buf, 32'h12345678);
    repeat (3) @(negedge clk);
    check_eq("t5_no_late_shift", {28'd0, ui_cnt}, 32'd0);

    // T6: async reset aborts lockout
    for (int r = 0; r < 3; r++) begin
      load_ui_nines();
      do_enter("t6", 1'b0, 1'b1);
    end
    repeat (4) @(negedge clk);
    check_eq("t6_locked_before", {31'd0, locked}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_async_locked", {31'd0, locked}, 32'd0);
    check_eq("t6_async_bufs", ui_buf | sp_buf, 32'h0);
    check_eq("t6_async_cnts", {24'd0, ui_cnt, sp_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_after_release", {29'd0, match, fail, locked}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
